// File: rtl/uart_fifo_ip_pkg.sv
// uart_fifo_ip_pkg: register map, STATUS/CTRL bit positions and FSM encodings
package uart_fifo_ip_pkg;
   localparam int DIV_W = 16;
   localparam logic [DIV_W-1:0] MIN_DIV = 16'd2;
   localparam logic [1:0] REG_DATA = 2'd0, REG_STATUS = 2'd1, REG_CTRL = 2'd2, REG_BAUD = 2'd3;
   localparam int ST_TX_FULL = 0, ST_TX_EMPTY = 1, ST_RX_FULL = 2, ST_RX_EMPTY = 3;
   localparam int ST_RX_OVR = 4, ST_TX_BUSY = 5, ST_TX_DROP = 6, ST_FRAME_ERR = 7, ST_RX_CNT = 8;
   localparam int CT_TX_EN = 0, CT_RX_EN = 1, CT_IRQ_RX = 2, CT_IRQ_TXE = 3, CT_CLR = 4, CT_FLUSH = 5;
   localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
endpackage

// File: rtl/uart_fifo_ip_sync_fifo.sv
// uart_sync_fifo: 8-bit synchronous FIFO with occupancy count and flush
module uart_sync_fifo #(
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  logic [7:0]    i_din,
   output logic [7:0]    o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);
   logic [7:0] r_mem [DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic w_push, w_pop;
   assign o_full = r_cnt == CW'(DEPTH);
   assign o_empty = r_cnt == '0;
   assign o_count = r_cnt;
   assign o_dout = r_mem[r_rp];
   assign w_pop = i_pop & ~o_empty;
   // a full FIFO still accepts a push when the same edge frees a slot
   assign w_push = i_push & (~o_full | w_pop);
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wp <= '0;
         r_rp <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PW'(1);
         if (w_pop) r_rp <= r_rp + PW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/uart_fifo_ip.sv
// uart_fifo_ip: memory-mapped 8N1 UART with TX/RX byte FIFOs and level interrupt
module uart_fifo_ip
   import uart_fifo_ip_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int DEFAULT_DIV = 434
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic                  we,
   input  logic                  re,
   output logic [DATA_WIDTH-1:0] rd,
   input  logic                  rx,
   output logic                  tx,
   output logic                  irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [1:0] w_a;
   logic w_wr_data, w_wr_ctrl, w_wr_baud, w_rd_pop, w_clr, w_flush, w_unused;
   logic r_tx_en, r_rx_en, r_irq_rx_en, r_irq_txe_en;
   logic r_rx_ovr, r_tx_drop, r_frame_err;
   logic [DIV_W-1:0] r_div;
   logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [CW-1:0] w_tx_count, w_rx_count;
   logic [7:0] w_tx_dout, w_rx_dout;
   logic [1:0] r_tx_st, r_rx_st;
   logic [DIV_W-1:0] r_tx_cnt, r_tx_div, r_rx_cnt, r_rx_div;
   logic [2:0] r_tx_bit, r_rx_bit;
   logic [7:0] r_tx_sh, r_rx_sh;
   logic r_rx_s1, r_rx_s2;
   logic w_tx_last, w_tx_pop, w_rx_last, w_rx_stop, w_rx_push, w_frame_set;
   logic [15:0] w_status;
   logic [3:0] w_ctrl;
   assign w_a = addr[1:0];
   assign w_unused = ^{addr[ADDR_WIDTH-1:2], wd[DATA_WIDTH-1:DIV_W], w_tx_count};
   assign w_wr_data = we & (w_a == REG_DATA);
   assign w_wr_ctrl = we & (w_a == REG_CTRL);
   assign w_wr_baud = we & (w_a == REG_BAUD);
   assign w_rd_pop = re & (w_a == REG_DATA);
   assign w_clr = w_wr_ctrl & wd[CT_CLR];
   assign w_flush = w_wr_ctrl & wd[CT_FLUSH];
   always_ff @(posedge clk) begin
      if (rst) begin
         {r_tx_en, r_rx_en, r_irq_rx_en, r_irq_txe_en} <= '0;
         {r_rx_ovr, r_tx_drop, r_frame_err} <= '0;
         r_div <= DIV_W'(DEFAULT_DIV);
      end else begin
         if (w_wr_ctrl) begin
            r_tx_en <= wd[CT_TX_EN];
            r_rx_en <= wd[CT_RX_EN];
            r_irq_rx_en <= wd[CT_IRQ_RX];
            r_irq_txe_en <= wd[CT_IRQ_TXE];
         end
         if (w_wr_baud) r_div <= (wd[DIV_W-1:0] < MIN_DIV) ? MIN_DIV : wd[DIV_W-1:0];
         r_tx_drop <= (r_tx_drop & ~w_clr) | (w_wr_data & w_tx_full & ~w_tx_pop & ~w_flush);
         r_rx_ovr <= (r_rx_ovr & ~w_clr) | (w_rx_push & w_rx_full & ~w_rd_pop & ~w_flush);
         r_frame_err <= (r_frame_err & ~w_clr) | w_frame_set;
      end
   end
   uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .i_push(w_wr_data), .i_pop(w_tx_pop), .i_flush(w_flush),
      .i_din(wd[7:0]), .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty),
      .o_count(w_tx_count)
   );
   uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .i_push(w_rx_push), .i_pop(w_rd_pop), .i_flush(w_flush),
      .i_din(r_rx_sh), .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty),
      .o_count(w_rx_count)
   );
   // a new frame starts from IDLE or straight out of the last STOP cycle
   assign w_tx_last = r_tx_cnt == r_tx_div - DIV_W'(1);
   assign w_tx_pop = r_tx_en & ~w_tx_empty & ~w_flush &
                     ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_last));
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_st <= S_IDLE;
         r_tx_cnt <= '0;
         r_tx_bit <= '0;
      end else if (w_tx_pop) begin
         r_tx_st <= S_START;
         r_tx_cnt <= '0;
         r_tx_bit <= '0;
         r_tx_div <= r_div;
         r_tx_sh <= w_tx_dout;
      end else if (r_tx_st != S_IDLE) begin
         r_tx_cnt <= w_tx_last ? '0 : r_tx_cnt + DIV_W'(1);
         if (w_tx_last) begin
            if (r_tx_st == S_START) r_tx_st <= S_DATA;
            else if (r_tx_st == S_DATA) begin
               r_tx_sh <= r_tx_sh >> 1;
               r_tx_bit <= r_tx_bit + 3'd1;
               if (r_tx_bit == 3'd7) r_tx_st <= S_STOP;
            end else r_tx_st <= S_IDLE;
         end
      end
   end
   assign tx = (r_tx_st == S_START) ? 1'b0 : (r_tx_st == S_DATA) ? r_tx_sh[0] : 1'b1;
   always_ff @(posedge clk) begin
      if (rst) {r_rx_s1, r_rx_s2} <= 2'b11;
      else {r_rx_s1, r_rx_s2} <= {rx, r_rx_s1};
   end
   // START waits half a bit so every later sample lands mid-bit
   assign w_rx_last = r_rx_cnt == (((r_rx_st == S_START) ? (r_rx_div >> 1) : r_rx_div) - DIV_W'(1));
   assign w_rx_stop = r_rx_en & (r_rx_st == S_STOP) & w_rx_last;
   assign w_rx_push = w_rx_stop & r_rx_s2;
   assign w_frame_set = w_rx_stop & ~r_rx_s2;
   always_ff @(posedge clk) begin
      if (rst || !r_rx_en) begin
         r_rx_st <= S_IDLE;
         r_rx_cnt <= '0;
         r_rx_bit <= '0;
      end else if (r_rx_st == S_IDLE) begin
         if (!r_rx_s2) begin
            r_rx_st <= S_START;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_div <= r_div;
         end
      end else begin
         r_rx_cnt <= w_rx_last ? '0 : r_rx_cnt + DIV_W'(1);
         if (w_rx_last) begin
            if (r_rx_st == S_START) r_rx_st <= r_rx_s2 ? S_IDLE : S_DATA;
            else if (r_rx_st == S_DATA) begin
               r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
               r_rx_bit <= r_rx_bit + 3'd1;
               if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
            end else r_rx_st <= S_IDLE;
         end
      end
   end
   assign irq = (r_irq_rx_en & ~w_rx_empty) | (r_irq_txe_en & w_tx_empty & (r_tx_st == S_IDLE));
   always_comb begin
      w_status = '0;
      w_status[ST_TX_FULL] = w_tx_full;
      w_status[ST_TX_EMPTY] = w_tx_empty;
      w_status[ST_RX_FULL] = w_rx_full;
      w_status[ST_RX_EMPTY] = w_rx_empty;
      w_status[ST_RX_OVR] = r_rx_ovr;
      w_status[ST_TX_BUSY] = r_tx_st != S_IDLE;
      w_status[ST_TX_DROP] = r_tx_drop;
      w_status[ST_FRAME_ERR] = r_frame_err;
      w_status[ST_RX_CNT +: 8] = 8'(w_rx_count);
      w_ctrl = '0;
      w_ctrl[CT_TX_EN] = r_tx_en;
      w_ctrl[CT_RX_EN] = r_rx_en;
      w_ctrl[CT_IRQ_RX] = r_irq_rx_en;
      w_ctrl[CT_IRQ_TXE] = r_irq_txe_en;
      rd = (w_a == REG_DATA)   ? DATA_WIDTH'(w_rx_empty ? 8'd0 : w_rx_dout) :
           (w_a == REG_STATUS) ? DATA_WIDTH'(w_status) :
           (w_a == REG_CTRL)   ? DATA_WIDTH'(w_ctrl) : DATA_WIDTH'(r_div);
   end
endmodule

// File: doc/uart_fifo_ip.md
UART_FIFO_IP -- requirements
Module: uart_fifo_ip

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bus data width.
REQ-002 Parameter ADDR_WIDTH, default 32, word-index address width; only addr[1:0] decoded.
REQ-003 Parameter FIFO_DEPTH, default 8, entries per TX/RX FIFO, power of two, 2..256.
REQ-004 Parameter DEFAULT_DIV, default 434, reset baud divisor in clk cycles per bit.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 addr  input  ADDR_WIDTH  register word index.
REQ-008 wd  input  DATA_WIDTH  write data.
REQ-009 we  input  1  write strobe, one access per cycle.
REQ-010 re  input  1  read strobe; needed only for the DATA pop side effect.
REQ-011 rd  output  DATA_WIDTH  combinational read data for addr.
REQ-012 rx  input  1  serial in, asynchronous to clk.
REQ-013 tx  output  1  serial out, idle high.
REQ-014 irq  output  1  level interrupt.

Function
REQ-015 Map: 0 DATA, 1 STATUS (RO), 2 CTRL, 3 BAUD_DIV; unused rd bits read 0.
REQ-016 DATA write pushes wd[7:0] to TX FIFO; if full and no same-cycle pop, byte dropped, STATUS.tx_drop set.
REQ-017 DATA read returns RX FIFO head zero-extended; re on DATA pops at the edge; read of empty returns 0, no pop.
REQ-018 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_overrun, [5] tx_busy, [6] tx_drop, [7] frame_err, [15:8] rx_count.
REQ-019 CTRL: [0] tx_en, [1] rx_en, [2] irq_rx_en, [3] irq_txe_en; [4] clear sticky bits 4/6/7; [5] flush both FIFOs; bits 4/5 self-clear, read 0.
REQ-020 BAUD_DIV writes below 2 store 2; TX/RX latch divisor at frame start, so changes apply next frame.
REQ-021 FIFO: same-cycle push and pop both occur, count unchanged; push on full with concurrent pop accepted; pop on empty ignored; pointers wrap modulo FIFO_DEPTH.
REQ-022 TX FSM IDLE->START->DATA->STOP->IDLE, 8N1, LSB first, each bit exactly DIV cycles.
REQ-023 TX leaves IDLE the cycle after tx_en=1 and FIFO non-empty, popping the byte; STOP goes back-to-back to START if more data.
REQ-024 tx_en cleared mid-frame completes the current frame, then holds IDLE.
REQ-025 rx passes a 2-flop synchroniser; RX FSM IDLE->START->DATA->STOP->IDLE, active only with rx_en=1.
REQ-026 RX START samples at DIV/2 after the falling edge; high there returns IDLE, false start, nothing logged.
REQ-027 RX samples each data bit and stop bit DIV cycles apart at mid-bit.
REQ-028 Stop=1 pushes byte; if RX FIFO full, byte dropped, rx_overrun set.
REQ-029 Stop=0 sets frame_err, byte discarded.
REQ-030 irq = (irq_rx_en & !rx_empty) | (irq_txe_en & tx_empty & !tx_busy).
REQ-031 Flush empties FIFOs next edge, no in-progress frame aborted; flush wins over same-cycle push/pop.

Reset
REQ-032 rst clears FIFOs and sticky bits, both FSMs IDLE, CTRL=0, BAUD_DIV=DEFAULT_DIV.
REQ-033 During/after rst: tx=1, irq=0, STATUS=0x0A (both FIFOs empty).
REQ-034 rst mid-frame aborts the frame immediately; partial RX byte discarded.

Structure
REQ-035 Shared package holds register indices, STATUS/CTRL bit positions, FSM state encodings, minimum divisor 2.
REQ-036 One sub-module uart_sync_fifo (8-bit, FIFO_DEPTH, full/empty/count) instantiated for TX and RX.

Verification (DIV=4, FIFO_DEPTH=4)
REQ-037 tx_en=1, write 0xA5 -> tx low 4 cycles, bits 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; tx_empty irq with irq_txe_en.
REQ-038 Drive 0x3C frame on rx, rx_en=1 -> rx_count=1, DATA read 0x3C, then rx_empty=1, count 0.
REQ-039 tx_en=0, write 5 bytes -> tx_full after 4, tx_drop=1; CTRL[4] clears it.
REQ-040 Send 5 frames unread -> rx_full, rx_overrun=1, first 4 bytes intact in order.
REQ-041 rx low 1 cycle -> no push; frame with stop=0 -> frame_err=1, no push.
REQ-042 rst mid-TX frame -> tx=1 next cycle, STATUS=0x0A, BAUD_DIV=DEFAULT_DIV.
